button_conditioner: RTL and testbench

- Conditions one raw push-button input into clean, single-cycle control pulses.
- Sits directly upstream of the reset/load and start/stop state machines in the stopwatch top level; one instance per button (button_rl, button_ss).
- Synchronises the asynchronous input, debounces it with a cycle counter, and emits a debounced level, press/release pulses and a long-press pulse.

---
 rtl/button_conditioner.sv | 181 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner
//   Turns one raw, bouncy push-button input into clean control signals for the
//   stopwatch state machines. The asynchronous input passes through a two-flop
//   synchroniser, is debounced by a four-state FSM with a sample counter, and
//   produces a debounced level plus single-cycle press, release and long-press
//   pulses. All outputs are registered; nothing is combinational from btn_raw.
//
//   Optional feature: define BUTTON_CONDITIONER_AUTO_REPEAT_EN to make
//   press_pulse re-fire every REPEAT_CYCLES cycles while the button stays held
//   after long_pulse.
//
// Ports
//   clk            in   system clock, rising edge
//   reset_b        in   asynchronous active-low reset
//   btn_raw        in   raw asynchronous button, active-high
//   btn_level      out  debounced button level
//   press_pulse    out  one-cycle pulse on accepted press (and auto-repeats)
//   release_pulse  out  one-cycle pulse on accepted release
//   long_pulse     out  one-cycle pulse when the hold reaches LONG_CYCLES

module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LONG_CYCLES     = 16,
    parameter int unsigned REPEAT_CYCLES   = 8,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic reset_b,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LongMax = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StPressChk,
        StHeld,
        StReleaseChk
    } state_e;

    logic             sync1_q, sync2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] hold_cnt_inc;
    logic             btn_level_q, btn_level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RepLast = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    // Saturating hold counter so long_pulse cannot re-fire within one press.
    assign hold_cnt_inc = (hold_cnt_q == LongMax) ? hold_cnt_q : hold_cnt_q + CntOne;

    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        btn_level_d = btn_level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        rep_cnt_d   = '0;
`endif
        unique case (state_q)
            StIdle: begin
                deb_cnt_d   = '0;
                hold_cnt_d  = '0;
                btn_level_d = 1'b0;
                if (sync2_q) begin
                    state_d   = StPressChk;
                    deb_cnt_d = CntOne;
                end
            end
            StPressChk: begin
                if (!sync2_q) begin
                    state_d   = StIdle;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLast) begin
                    state_d     = StHeld;
                    deb_cnt_d   = '0;
                    hold_cnt_d  = CntOne;
                    btn_level_d = 1'b1;
                    press_d     = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CntOne;
                end
            end
            StHeld: begin
                btn_level_d = 1'b1;
                hold_cnt_d  = hold_cnt_inc;
                if (!sync2_q) begin
                    state_d   = StReleaseChk;
                    deb_cnt_d = CntOne;
                end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
                // Repeat period starts the cycle after long_pulse (hold saturated).
                else if (hold_cnt_q == LongMax) begin
                    if (rep_cnt_q == RepLast) begin
                        press_d   = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CntOne;
                    end
                end
`endif
            end
            StReleaseChk: begin
                btn_level_d = 1'b1;
                hold_cnt_d  = hold_cnt_inc;
                if (sync2_q) begin
                    state_d   = StHeld;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLast) begin
                    state_d     = StIdle;
                    deb_cnt_d   = '0;
                    hold_cnt_d  = '0;
                    btn_level_d = 1'b0;
                    release_d   = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Fires only on the cycle the count first reaches LONG_CYCLES.
        long_d = (hold_cnt_d == LongMax) && (hold_cnt_q != LongMax);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= StIdle;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            btn_level_q <= btn_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: table-driven vectors, hand-written reset and
// long-press sequences, and randomized stimulus against a behavioural model.

module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int LONG = 16;
    localparam int REP  = 8;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int HOLD       = 40;
    localparam int EXP_PRESSES = 3;
`else
    localparam int HOLD       = 30;
    localparam int EXP_PRESSES = 1;
`endif

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_level, press_pulse, release_pulse, long_pulse;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .REPEAT_CYCLES  (REP),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] dut_vec();
        return {btn_level, press_pulse, release_pulse, long_pulse};
    endfunction

    // Behavioural model: level flips once the last DEB synchronised samples all
    // disagree with it; pulses derive from level edges and time spent high.
    logic     m_s1, m_s2, m_level, m_prev_sample;
    bit       m_win[$];
    int       m_hold, m_rep;
    logic [3:0] exp_vec;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_prev_sample = 0;
        m_win.delete();
        m_hold = 0; m_rep = 0; exp_vec = 4'b0000;
    endtask

    task automatic model_step();
        logic sample, lvl_old, all_opp, in_held_old, prs, rel, lng;
        int   hold_old;
        sample = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_raw;
        m_win.push_back(sample);
        if (m_win.size() > DEB) void'(m_win.pop_front());
        lvl_old = m_level;
        all_opp = (m_win.size() == DEB);
        foreach (m_win[k]) if (m_win[k] == lvl_old) all_opp = 0;
        if (all_opp) m_level = !m_level;
        hold_old = m_hold;
        in_held_old = lvl_old && m_prev_sample;
        m_hold = m_level ? m_hold + 1 : 0;
        prs = m_level && !lvl_old;
        rel = !m_level && lvl_old;
        lng = m_level && (m_hold == LONG);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        if (in_held_old && sample && hold_old >= LONG) begin
            m_rep++;
            if (m_rep == REP) begin
                prs = 1;
                m_rep = 0;
            end
        end else begin
            m_rep = 0;
        end
`else
        if (in_held_old && hold_old < 0) m_rep = 0;
`endif
        m_prev_sample = sample;
        exp_vec = {m_level, prs, rel, lng};
    endtask

    // One clock: advance model at the edge, compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!reset_b) model_reset();
        else model_step();
        #1;
        check("model", int'(dut_vec()), int'(exp_vec));
        check("press_and_release", int'(press_pulse & release_pulse), 0);
    endtask

    typedef struct {
        logic       raw;
        int         reps;
        logic [3:0] exp;
    } vec_t;

    function automatic vec_t mk(logic r, int n, logic [3:0] e);
        vec_t v;
        v.raw = r; v.reps = n; v.exp = e;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int   n, press_at, e, long_e, long_cnt, rel_cnt, rel_e;
        int   press_e[$];
        logic seen;

        // {level, press, release, long}
        // Clean press: 8 cycles high, then release.
        tbl.push_back(mk(1'b1, 5, 4'b0000));
        tbl.push_back(mk(1'b1, 1, 4'b1100));
        tbl.push_back(mk(1'b1, 2, 4'b1000));
        tbl.push_back(mk(1'b0, 5, 4'b1000));
        tbl.push_back(mk(1'b0, 1, 4'b0010));
        tbl.push_back(mk(1'b0, 3, 4'b0000));
        // Bounces of 1, 2, 3 cycles are rejected, then a real press.
        tbl.push_back(mk(1'b1, 1, 4'b0000));
        tbl.push_back(mk(1'b0, 4, 4'b0000));
        tbl.push_back(mk(1'b1, 2, 4'b0000));
        tbl.push_back(mk(1'b0, 4, 4'b0000));
        tbl.push_back(mk(1'b1, 3, 4'b0000));
        tbl.push_back(mk(1'b0, 4, 4'b0000));
        tbl.push_back(mk(1'b1, 5, 4'b0000));
        tbl.push_back(mk(1'b1, 1, 4'b1100));
        // Release bounce of 2 cycles is invisible, then a real release.
        tbl.push_back(mk(1'b1, 2, 4'b1000));
        tbl.push_back(mk(1'b0, 2, 4'b1000));
        tbl.push_back(mk(1'b1, 3, 4'b1000));
        tbl.push_back(mk(1'b0, 5, 4'b1000));
        tbl.push_back(mk(1'b0, 1, 4'b0010));
        tbl.push_back(mk(1'b0, 3, 4'b0000));

        model_reset();
        #13;
        check("reset_state", int'(dut_vec()), 0);
        #10;
        reset_b = 1'b1;
        repeat (5) tick();

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                btn_raw = tbl[i].raw;
                tick();
                check($sformatf("table[%0d]", i), int'(dut_vec()), int'(tbl[i].exp));
            end
        end

        // Asynchronous reset while held.
        btn_raw = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = btn_level;
        end
        check("level_before_reset", int'(seen), 1);
        #3;
        reset_b = 1'b0;
        model_reset();
        #1;
        check("async_reset", int'(dut_vec()), 0);
        tick();
        tick();
        #2;
        reset_b = 1'b1;
        press_at = -1;
        for (int i = 1; i <= 20 && press_at < 0; i++) begin
            tick();
            if (press_pulse) press_at = i;
        end
        check("press_after_reset_edges", press_at, 6);
        btn_raw = 1'b0;
        repeat (12) tick();
        check("idle_after_release", int'(dut_vec()), 0);

        // Long press.
        long_cnt = 0; rel_cnt = 0; long_e = -1; rel_e = -1;
        for (e = 1; e <= HOLD + 25; e++) begin
            btn_raw = (e <= HOLD);
            tick();
            if (press_pulse) press_e.push_back(e);
            if (long_pulse) begin
                long_cnt++;
                long_e = e;
            end
            if (release_pulse) begin
                rel_cnt++;
                rel_e = e;
            end
        end
        check("long_count", long_cnt, 1);
        check("long_after_press", (press_e.size() > 0) ? long_e - press_e[0] : -1, LONG - 1);
        check("long_release_count", rel_cnt, 1);
        check("long_release_edge", rel_e, HOLD + 1 + DEB + 1);
        check("long_press_count", press_e.size(), EXP_PRESSES);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        check("repeat1_offset", (press_e.size() > 1) ? press_e[1] - long_e : -1, REP);
        check("repeat2_offset", (press_e.size() > 2) ? press_e[2] - long_e : -1, 2 * REP);
`endif

        // Randomized runs with one mid-run asynchronous reset.
        n = 0;
        while (n < 1500) begin
            logic v;
            int   len;
            v = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 30) : $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                btn_raw = v;
                tick();
                n++;
            end
            if (n >= 700 && n < 730) begin
                #2;
                reset_b = 1'b0;
                model_reset();
                #1;
                check("random_async_reset", int'(dut_vec()), 0);
                tick();
                #2;
                reset_b = 1'b1;
                n = 730;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
